// File: rtl/encoder_4x2.sv
// Registered 4-to-2 priority encoder with valid/multi-hot flags and a saturating multi-hot counter.
// Latency 1 cycle from Y to every output; en=0 freezes all state except the clr path on multi_cnt.
module encoder_4x2 #(
    parameter bit HI_PRIORITY  = 1'b1,
    parameter bit HOLD_ON_ZERO = 1'b0,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [3:0]       Y,
    output logic [1:0]       A,
    output logic             valid,
    output logic             multi,
    output logic [CNT_W-1:0] multi_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       a_q, a_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       win_idx;
    logic             any_set;
    logic             multi_hot;

    // Later loop iterations overwrite earlier ones, so iteration order picks the priority.
    always_comb begin
        win_idx = 2'b00;
        if (HI_PRIORITY) begin
            for (int i = 0; i < 4; i++) begin
                if (Y[i]) win_idx = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (Y[i]) win_idx = 2'(i);
            end
        end
    end

    assign any_set   = |Y;
    // Clearing the lowest set bit leaves something behind only if two or more bits were set.
    assign multi_hot = (Y & (Y - 4'd1)) != 4'd0;

    always_comb begin
        a_d     = a_q;
        valid_d = valid_q;
        multi_d = multi_q;
        cnt_d   = cnt_q;
        if (en) begin
            valid_d = any_set;
            multi_d = multi_hot;
            if (any_set) begin
                a_d = win_idx;
            end else if (!HOLD_ON_ZERO) begin
                a_d = 2'b00;
            end
            if (multi_hot && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= 2'b00;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A         = a_q;
    assign valid     = valid_q;
    assign multi     = multi_q;
    assign multi_cnt = cnt_q;

endmodule

// File: tb/tb_encoder_4x2.sv
// Bench for encoder_4x2: four parameterisations share one stimulus stream, scoreboarded against a behavioural model.
module tb_encoder_4x2;

    typedef struct packed {
        logic [1:0] a;
        logic       v;
        logic       m;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] Y;

    logic [1:0] a0, a1, a2, a3;
    logic       v0, v1, v2, v3;
    logic       m0, m1, m2, m3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    int n_cmp = 0;
    int n_err = 0;

    // Per-instance model configuration: 0=defaults, 1=hold-on-zero, 2=low priority, 3=2-bit counter
    bit    cfg_hi   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit    cfg_hold [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int    cfg_max  [4] = '{255, 255, 255, 3};
    string dut_name [4] = '{"def", "hold", "lo", "c2"};

    logic [1:0] m_a   [4];
    bit         m_v   [4];
    bit         m_m   [4];
    int         m_cnt [4];
    exp_t       sb    [4][$];

    always #5 clk = ~clk;

    encoder_4x2 u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Y(Y),
        .A(a0), .valid(v0), .multi(m0), .multi_cnt(c0));
    encoder_4x2 #(.HOLD_ON_ZERO(1'b1)) u_hold (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Y(Y),
        .A(a1), .valid(v1), .multi(m1), .multi_cnt(c1));
    encoder_4x2 #(.HI_PRIORITY(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Y(Y),
        .A(a2), .valid(v2), .multi(m2), .multi_cnt(c2));
    encoder_4x2 #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .Y(Y),
        .A(a3), .valid(v3), .multi(m3), .multi_cnt(c3));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_win(input logic [3:0] y, input bit hi);
        if (hi) begin
            if (y[3]) return 2'd3;
            else if (y[2]) return 2'd2;
            else if (y[1]) return 2'd1;
            else return 2'd0;
        end else begin
            if (y[0]) return 2'd0;
            else if (y[1]) return 2'd1;
            else if (y[2]) return 2'd2;
            else if (y[3]) return 2'd3;
            else return 2'd0;
        end
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 4; k++) begin
            m_a[k] = 2'b00; m_v[k] = 1'b0; m_m[k] = 1'b0; m_cnt[k] = 0;
            sb[k].delete();
        end
    endtask

    // Apply inputs for the next edge and push the model's post-edge expectation.
    task automatic drive(input logic [3:0] y, input logic e, input logic c);
        exp_t x;
        Y = y; en = e; clr = c;
        for (int k = 0; k < 4; k++) begin
            if (e) begin
                m_v[k] = (y != 4'd0);
                m_m[k] = ($countones(y) >= 2);
                if (y != 4'd0) m_a[k] = ref_win(y, cfg_hi[k]);
                else if (!cfg_hold[k]) m_a[k] = 2'b00;
                if (m_m[k] && m_cnt[k] < cfg_max[k]) m_cnt[k]++;
            end
            if (c) m_cnt[k] = 0;
            x.a = m_a[k]; x.v = m_v[k]; x.m = m_m[k]; x.cnt = 8'(m_cnt[k]);
            sb[k].push_back(x);
        end
    endtask

    // Advance one edge, then pop and compare each instance's expectation.
    task automatic tick();
        exp_t obs [4];
        exp_t x;
        @(posedge clk);
        #1;
        obs[0] = {a0, v0, m0, c0};
        obs[1] = {a1, v1, m1, c1};
        obs[2] = {a2, v2, m2, c2};
        obs[3] = {a3, v3, m3, 6'b0, c3};
        for (int k = 0; k < 4; k++) begin
            if (sb[k].size() == 0) begin
                n_cmp++; n_err++;
                $error("FAIL sb_%s_empty observed=0 expected=1", dut_name[k]);
            end else begin
                x = sb[k].pop_front();
                chk({dut_name[k], ".A"},     {6'b0, obs[k].a}, {6'b0, x.a});
                chk({dut_name[k], ".valid"}, {7'b0, obs[k].v}, {7'b0, x.v});
                chk({dut_name[k], ".multi"}, {7'b0, obs[k].m}, {7'b0, x.m});
                chk({dut_name[k], ".cnt"},   obs[k].cnt,       x.cnt);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".def"},  {a0, v0, m0, 4'b0} | c0, 8'h00);
        chk({tag, ".hold"}, {a1, v1, m1, 4'b0} | c1, 8'h00);
        chk({tag, ".lo"},   {a2, v2, m2, 4'b0} | c2, 8'h00);
        chk({tag, ".c2"},   {a3, v3, m3, 3'b0, c3},  8'h00);
    endtask

    initial begin
        logic [1:0] sweep_a [16];
        logic [7:0] cnt_before;
        logic [1:0] c2_seq [5];
        sweep_a = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                    2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        c2_seq  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset is visible before any clock edge
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; Y = 4'd0;
        reset_model();
        #2;
        chk_all_zero("reset_async");
        #10;
        rst_n = 1'b1;

        // Full sweep of Y with the literal expected index table
        for (int y = 0; y < 16; y++) begin
            drive(4'(y), 1'b1, 1'b0);
            tick();
            chk($sformatf("sweep_A_%0d", y), {6'b0, a0}, {6'b0, sweep_a[y]});
            chk($sformatf("sweep_valid_%0d", y), {7'b0, v0}, (y != 0) ? 8'd1 : 8'd0);
        end

        // Hold-on-zero keeps the last index while valid drops
        drive(4'b0101, 1'b1, 1'b0); tick();
        chk("hold_0101", {3'b0, a1, v1, m1, 1'b0}, {3'b0, 2'b10, 1'b1, 1'b1, 1'b0});
        drive(4'b0000, 1'b1, 1'b0); tick();
        chk("hold_0000", {3'b0, a1, v1, m1, 1'b0}, {3'b0, 2'b10, 1'b0, 1'b0, 1'b0});
        chk("nohold_0000_A", {6'b0, a0}, 8'd0);

        // Low-priority instance
        drive(4'b1100, 1'b1, 1'b0); tick();
        chk("lo_1100", {5'b0, a2, m2}, {5'b0, 2'b10, 1'b1});
        chk("hi_1100", {5'b0, a0, m0}, {5'b0, 2'b11, 1'b1});
        drive(4'b1000, 1'b1, 1'b0); tick();
        chk("lo_1000", {5'b0, a2, m2}, {5'b0, 2'b11, 1'b0});
        drive(4'b0110, 1'b1, 1'b0); tick();
        chk("lo_0110", {6'b0, a2}, 8'd1);
        chk("hi_0110", {6'b0, a0}, 8'd2);

        // Enable low freezes outputs and counter
        drive(4'b0001, 1'b1, 1'b0); tick();
        cnt_before = c0;
        drive(4'b1000, 1'b0, 1'b0); tick();
        drive(4'b1111, 1'b0, 1'b0); tick();
        chk("en0_A", {6'b0, a0}, 8'd0);
        chk("en0_cnt", c0, cnt_before);

        // Saturation on the 2-bit counter, then clear beats increment
        drive(4'b0000, 1'b1, 1'b1); tick();
        chk("clr_cnt_def", c0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1, 1'b0); tick();
            chk($sformatf("c2_sat_%0d", i), {6'b0, c3}, {6'b0, c2_seq[i]});
        end
        chk("def_cnt_5", c0, 8'd5);
        drive(4'b1111, 1'b1, 1'b1); tick();
        chk("clr_over_inc_c2", {6'b0, c3}, 8'd0);
        chk("clr_over_inc_def", c0, 8'd0);
        drive(4'b1010, 1'b1, 1'b0); tick();
        drive(4'b0000, 1'b0, 1'b1); tick();
        chk("clr_en0", c0, 8'd0);

        // Mid-cycle reset with A=11 discards the pending sample
        drive(4'b1000, 1'b1, 1'b0); tick();
        chk("pre_reset_A", {6'b0, a0}, 8'd3);
        Y = 4'b1111; en = 1'b1; clr = 1'b0;
        rst_n = 1'b0;
        reset_model();
        #2;
        chk_all_zero("reset_mid");
        @(posedge clk); #1;
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        drive(4'b1111, 1'b0, 1'b0); tick();
        chk("post_reset_en0_A", {6'b0, a0}, 8'd0);
        drive(4'b0100, 1'b1, 1'b0); tick();
        chk("post_reset_first_A", {6'b0, a0}, 8'd2);
        chk("post_reset_first_valid", {7'b0, v0}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
